// File: rtl/fabric_pkg.sv
// Shared types and default sizing for the fabric request issuer.
package fabric_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } issuer_state_t;

  // Queued command layout at the default width: type bit above the payload.
  typedef struct packed {
    logic                 write;
    logic [DEF_WIDTH-1:0] data;
  } fabric_cmd_t;

endpackage

// File: rtl/fabric_cmd_fifo.sv
// Small command FIFO with registered full/empty flags and occupancy count.
module fabric_cmd_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          full_reg, empty_reg;
  logic          do_push, do_pop;

  assign do_push  = push && !full_reg;
  assign do_pop   = pop && !empty_reg;
  assign pop_data = mem[rd_ptr_reg];
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign count    = count_reg;

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) count_next = count_reg + 1'b1;
    else if (!do_push && do_pop) count_next = count_reg - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == FULL_COUNT);
      empty_reg <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/fabric_req_issuer.sv
// Queues upstream commands and issues them one at a time to the fabric,
// returning a response (or a timeout error) for each.
module fabric_req_issuer
  import fabric_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             fab_read_req,
  output logic             fab_write_req,
  output logic [WIDTH-1:0] fab_write_data,
  input  logic [WIDTH-1:0] fab_read_data,
  input  logic             fab_resp_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_write,
  output logic             rsp_err,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE_ENTRY = CW'(1);

  // Same layout as fabric_cmd_t, sized by this instance's WIDTH.
  typedef struct packed {
    logic             write;
    logic [WIDTH-1:0] data;
  } cmd_t;

  issuer_state_t state_reg;
  logic [TW-1:0] tmo_reg;
  logic          cur_write_reg;

  cmd_t          push_cmd, head_cmd;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          stays_idle, fifo_nonempty_next, busy_next;

  assign push_cmd.write = cmd_write;
  assign push_cmd.data  = cmd_data;
  assign cmd_ready      = !fifo_full;
  assign fifo_push      = cmd_valid && !fifo_full;
  assign fifo_pop       = (state_reg == IDLE) && !fifo_empty;

  fabric_cmd_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // busy is registered, so it is computed from next-cycle state and occupancy.
  assign stays_idle = ((state_reg == IDLE) && fifo_empty) ||
                      ((state_reg == RESP) && rsp_ready);
  assign fifo_nonempty_next = fifo_push || (fifo_count > ONE_ENTRY) ||
                              (!fifo_empty && !fifo_pop);
  assign busy_next = !stays_idle || fifo_nonempty_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      tmo_reg        <= '0;
      cur_write_reg  <= 1'b0;
      fab_read_req   <= 1'b0;
      fab_write_req  <= 1'b0;
      fab_write_data <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_write      <= 1'b0;
      rsp_err        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      fab_read_req   <= 1'b0;
      fab_write_req  <= 1'b0;
      fab_write_data <= '0;
      busy           <= busy_next;
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            cur_write_reg  <= head_cmd.write;
            fab_write_req  <= head_cmd.write;
            fab_read_req   <= !head_cmd.write;
            fab_write_data <= head_cmd.write ? head_cmd.data : '0;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (fab_resp_valid) begin
            rsp_data  <= cur_write_reg ? '0 : fab_read_data;
            rsp_write <= cur_write_reg;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end else if (tmo_reg == TMO_LAST) begin
            rsp_data  <= '0;
            rsp_write <= cur_write_reg;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fabric_req_issuer.sv
// Directed self-checking bench for fabric_req_issuer.
module tb_fabric_req_issuer;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [WIDTH-1:0] cmd_data;
  logic             fab_read_req, fab_write_req;
  logic [WIDTH-1:0] fab_write_data, fab_read_data;
  logic             fab_resp_valid;
  logic             rsp_valid, rsp_ready, rsp_write, rsp_err, busy;
  logic [WIDTH-1:0] rsp_data;

  always #5 clk = ~clk;

  fabric_req_issuer #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_data       (cmd_data),
    .fab_read_req   (fab_read_req),
    .fab_write_req  (fab_write_req),
    .fab_write_data (fab_write_data),
    .fab_read_data  (fab_read_data),
    .fab_resp_valid (fab_resp_valid),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_write      (rsp_write),
    .rsp_err        (rsp_err),
    .busy           (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fabric request monitor: one full cycle per ISSUE, so sample on negedge.
  logic        mon_wr[$];
  logic [31:0] mon_data[$];
  int          dual_req = 0;
  always @(negedge clk) begin
    if (fab_read_req && fab_write_req) dual_req++;
    else if (fab_read_req || fab_write_req) begin
      mon_wr.push_back(fab_write_req);
      mon_data.push_back(fab_write_data);
    end
  end

  logic        rq_wr[$];
  logic [31:0] rq_data[$];
  logic        rq_err[$];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rreq"},  fab_read_req, 0);
    check({tag, "_wreq"},  fab_write_req, 0);
    check({tag, "_wdata"}, fab_write_data, 0);
    check({tag, "_rvld"},  rsp_valid, 0);
    check({tag, "_rdata"}, rsp_data, 0);
    check({tag, "_rwr"},   rsp_write, 0);
    check({tag, "_rerr"},  rsp_err, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_crdy"},  cmd_ready, 1);
  endtask

  // One command from an idle issuer through to an accepted response.
  task automatic do_txn(input string tag, input logic wr, input logic [31:0] d,
                        input logic [31:0] rd, input logic tmo);
    logic [31:0] exp_data;
    exp_data = (wr || tmo) ? 32'h0 : rd;
    check({tag, "_crdy"}, cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_data = d;
    tick();
    cmd_valid = 0; cmd_data = 0;
    check({tag, "_busy"}, busy, 1);
    tick();
    check({tag, "_wreq"},  fab_write_req, wr);
    check({tag, "_rreq"},  fab_read_req, !wr);
    check({tag, "_wdata"}, fab_write_data, wr ? d : 32'h0);
    if (!tmo) begin fab_resp_valid = 1; fab_read_data = rd; end
    tick();
    check({tag, "_req_off"}, {fab_read_req, fab_write_req}, 0);
    check({tag, "_early"}, rsp_valid, 0);
    if (!tmo) begin
      tick();
      fab_resp_valid = 0;
    end else begin
      for (int i = 0; i < TIMEOUT - 1; i++) tick();
      check({tag, "_tmo_early"}, rsp_valid, 0);
      tick();
    end
    check({tag, "_rvld"},  rsp_valid, 1);
    check({tag, "_rdata"}, rsp_data, exp_data);
    check({tag, "_rwr"},   rsp_write, wr);
    check({tag, "_rerr"},  rsp_err, tmo);
    tick();
    check({tag, "_hold_vld"},  rsp_valid, 1);
    check({tag, "_hold_data"}, rsp_data, exp_data);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check({tag, "_done_vld"},  rsp_valid, 0);
    check({tag, "_done_busy"}, busy, 0);
    $display("txn %s wr=%0d data=%08h rsp=%08h err=%0d", tag, wr, d, rsp_data, rsp_err);
  endtask

  task automatic drain(input int n);
    int got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      if (rsp_valid) begin
        rq_wr.push_back(rsp_write);
        rq_data.push_back(rsp_data);
        rq_err.push_back(rsp_err);
        $display("txn rsp wr=%0d data=%08h err=%0d", rsp_write, rsp_data, rsp_err);
        got++;
      end
      tick();
    end
    check("drain_cnt", got, n);
  endtask

  logic        fill_wr[5]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] fill_d[5]    = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h13579BDF};
  logic [31:0] fill_rsp[5]  = '{32'h0BADF00D, 32'h0, 32'h22222222, 32'h22222222, 32'h0};
  logic        ord_wr[3]    = '{1'b1, 1'b0, 1'b0};
  logic [31:0] ord_d[3]     = '{32'hDEADBEEF, 32'h0, 32'h0};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_data = 0;
    fab_read_data = 0; fab_resp_valid = 0; rsp_ready = 0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 0;
    tick();
    check("idle_busy", busy, 0);

    do_txn("wr_a5", 1'b1, 32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0);
    do_txn("rd_a5", 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0);
    do_txn("tmo",   1'b0, 32'h0, 32'h77777777, 1'b1);
    do_txn("after_tmo", 1'b0, 32'h0, 32'h3C3C3C3C, 1'b0);

    // Fill: five back-to-back pushes, response held unaccepted.
    mon_wr.delete(); mon_data.delete();
    fab_resp_valid = 1; fab_read_data = 32'h0BADF00D; rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1; cmd_write = fill_wr[i]; cmd_data = fill_d[i];
      check($sformatf("fill_rdy%0d", i), cmd_ready, 1);
      tick();
    end
    check("fill_full", cmd_ready, 0);
    check("fill_rvld", rsp_valid, 1);
    cmd_write = 1; cmd_data = 32'hFFFF0000;
    fab_read_data = 32'h22222222;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fill_blk%0d", i), cmd_ready, 0);
      check($sformatf("fill_hold%0d", i), rsp_data, 32'h0BADF00D);
    end
    cmd_valid = 0;
    rsp_ready = 1;
    rq_wr.delete(); rq_data.delete(); rq_err.delete();
    drain(5);
    for (int i = 0; i < 5; i++) begin
      if (i < rq_wr.size()) begin
        check($sformatf("fill_rwr%0d", i), rq_wr[i], fill_wr[i]);
        check($sformatf("fill_rdata%0d", i), rq_data[i], fill_rsp[i]);
        check($sformatf("fill_rerr%0d", i), rq_err[i], 0);
      end
    end
    check("fill_mon_cnt", mon_wr.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < mon_wr.size()) begin
        check($sformatf("fill_mon_wr%0d", i), mon_wr[i], fill_wr[i]);
        check($sformatf("fill_mon_d%0d", i), mon_data[i], fill_d[i]);
      end
    end
    tick(); tick();
    check("fill_end_busy", busy, 0);

    // Ordering: W, R, R with upstream always ready.
    mon_wr.delete(); mon_data.delete();
    rq_wr.delete(); rq_data.delete(); rq_err.delete();
    fab_read_data = 32'h44444444;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1; cmd_write = ord_wr[i]; cmd_data = ord_d[i];
      tick();
    end
    cmd_valid = 0;
    drain(3);
    check("ord_mon_cnt", mon_wr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < mon_wr.size()) begin
        check($sformatf("ord_wr%0d", i), mon_wr[i], ord_wr[i]);
        check($sformatf("ord_d%0d", i), mon_data[i], ord_d[i]);
      end
      if (i < rq_data.size())
        check($sformatf("ord_rsp%0d", i), rq_data[i], ord_wr[i] ? 32'h0 : 32'h44444444);
    end
    rsp_ready = 0; fab_resp_valid = 0;
    tick(); tick();

    // Reset while waiting on the fabric with two commands queued.
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1; cmd_write = 1'b0; cmd_data = 32'h0;
      tick();
    end
    cmd_valid = 0;
    tick();
    check("mid_wait_busy", busy, 1);
    rst = 1;
    tick();
    rst = 0;
    check_reset_outputs("midrst");
    mon_wr.delete(); mon_data.delete();
    for (int i = 0; i < 20; i++) tick();
    check("midrst_noreq", mon_wr.size(), 0);
    check("midrst_busy", busy, 0);
    check("midrst_rvld", rsp_valid, 0);
    do_txn("post_rst", 1'b1, 32'h600DCAFE, 32'h0, 1'b0);

    // Stray fabric strobe while idle.
    fab_resp_valid = 1; fab_read_data = 32'h99999999;
    tick();
    fab_resp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stray_rvld%0d", i), rsp_valid, 0);
    end
    check("stray_busy", busy, 0);
    check("dual_req", dual_req, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
